beta_mem_arbiter: RTL

- Merges the core's three memory requesters onto one shared memory bus, one outstanding transaction at a time:
  - instruction fetch (read);
  - data read;
  - data write.
- Sits between the IF/EXE stage memory ports and a single unified memory or interconnect port.
- Priority order is write, then data read, then fetch, with a bounded-starvation guarantee for fetch.
- Request payload is latched at arbitration, so requesters never see bus backpressure except through their own ready/valid.

---
 rtl/beta_pkg.sv | 24 ++
 rtl/beta_arb_prio.sv | 60 ++++++
 rtl/beta_mem_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/beta_pkg.sv
// rtl/beta_pkg.sv - shared types and constants for the beta memory arbiter
// Contents: arbiter FSM states, requester port ids, fetch strobe, starve counter ceiling.
package beta_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_RESP
  } arb_state_t;

  typedef enum logic [1:0] {
    ARB_PORT_INSTR = 2'd0,
    ARB_PORT_RDATA = 2'd1,
    ARB_PORT_WDATA = 2'd2
  } arb_port_e;

  // Wide enough for any supported data width; users slice off DataWidth/8 bits.
  localparam int unsigned ARB_MAX_STRB_W = 64;
  localparam logic [ARB_MAX_STRB_W-1:0] ARB_FETCH_STRB = '1;

  // Saturation value of the 4-bit fetch starvation counter.
  localparam logic [3:0] ARB_STARVE_MAX = 4'hF;

endpackage

// File: rtl/beta_arb_prio.sv
// rtl/beta_arb_prio.sv - winner select with bounded fetch starvation
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   instr_req_i         fetch request pending
//   rdata_req_i         load request pending
//   wdata_req_i         store request pending
//   latch_i             arbitration happens this cycle (winner is taken)
//   winner_o            port that wins if latch_i is high
module beta_arb_prio
  import beta_pkg::*;
#(
  parameter int unsigned StarveLimit = 4
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      instr_req_i,
  input  logic      rdata_req_i,
  input  logic      wdata_req_i,
  input  logic      latch_i,
  output arb_port_e winner_o
);

  localparam logic [3:0] StarveLimitW = 4'(StarveLimit);

  logic [3:0] starve_cnt_q;
  logic [3:0] starve_cnt_d;

  // A waiting fetch that has been passed over StarveLimit times overrides
  // the fixed write > read > fetch order.
  always_comb begin
    winner_o = ARB_PORT_INSTR;
    if (instr_req_i && (starve_cnt_q == StarveLimitW)) begin
      winner_o = ARB_PORT_INSTR;
    end else if (wdata_req_i) begin
      winner_o = ARB_PORT_WDATA;
    end else if (rdata_req_i) begin
      winner_o = ARB_PORT_RDATA;
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (latch_i) begin
      if ((winner_o != ARB_PORT_INSTR) && instr_req_i) begin
        starve_cnt_d = (starve_cnt_q == ARB_STARVE_MAX) ? starve_cnt_q : starve_cnt_q + 4'd1;
      end else begin
        starve_cnt_d = 4'd0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_cnt_q <= 4'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/beta_mem_arbiter.sv
// rtl/beta_mem_arbiter.sv - merges fetch, load and store ports onto one memory bus
// Ports:
//   clk_i, rst_i                         clock, synchronous active-high reset
//   instr_req_i/addr_i, ready/valid/rdata  fetch port
//   rdata_req_i/addr_i/strb_i, ready/valid/data  load port
//   wdata_req_i/addr_i/data_i/strb_i, ready/valid  store port
//   mem_req_o/we_o/addr_o/wdata_o/strb_o  bus request and payload
//   mem_ready_i                          bus accepts the request
//   mem_valid_i/rdata_i                  bus response
//   busy_o                               a transaction is in flight
module beta_mem_arbiter
  import beta_pkg::*;
#(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddressWidth = 32,
  parameter int unsigned StarveLimit  = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    instr_req_i,
  input  logic [AddressWidth-1:0] instr_addr_i,
  output logic                    instr_ready_o,
  output logic                    instr_valid_o,
  output logic [DataWidth-1:0]    instr_rdata_o,
  input  logic                    rdata_req_i,
  input  logic [AddressWidth-1:0] rdata_addr_i,
  input  logic [DataWidth/8-1:0]  rdata_strb_i,
  output logic                    rdata_ready_o,
  output logic                    rdata_valid_o,
  output logic [DataWidth-1:0]    rdata_data_o,
  input  logic                    wdata_req_i,
  input  logic [AddressWidth-1:0] wdata_addr_i,
  input  logic [DataWidth-1:0]    wdata_data_i,
  input  logic [DataWidth/8-1:0]  wdata_strb_i,
  output logic                    wdata_ready_o,
  output logic                    wdata_valid_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [AddressWidth-1:0] mem_addr_o,
  output logic [DataWidth-1:0]    mem_wdata_o,
  output logic [DataWidth/8-1:0]  mem_strb_o,
  input  logic                    mem_ready_i,
  input  logic                    mem_valid_i,
  input  logic [DataWidth-1:0]    mem_rdata_i,
  output logic                    busy_o
);

  localparam int unsigned StrbWidth = DataWidth / 8;

  arb_state_t                  state_q, state_d;
  arb_port_e                   port_q, port_d;
  logic [AddressWidth-1:0]     addr_q, addr_d;
  logic [DataWidth-1:0]        wdata_q, wdata_d;
  logic [StrbWidth-1:0]        strb_q, strb_d;
  logic                        we_q, we_d;

  arb_port_e winner;
  logic      any_req;
  logic      latch;
  logic      in_req;
  logic      in_resp;

  assign any_req = instr_req_i | rdata_req_i | wdata_req_i;
  assign latch   = (state_q == ARB_IDLE) && any_req;
  assign in_req  = (state_q == ARB_REQ);
  assign in_resp = (state_q == ARB_RESP);

  beta_arb_prio #(
    .StarveLimit(StarveLimit)
  ) u_prio (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .instr_req_i(instr_req_i),
    .rdata_req_i(rdata_req_i),
    .wdata_req_i(wdata_req_i),
    .latch_i    (latch),
    .winner_o   (winner)
  );

  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    we_d    = we_q;
    case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          state_d = ARB_REQ;
          port_d  = winner;
          case (winner)
            ARB_PORT_WDATA: begin
              addr_d  = wdata_addr_i;
              wdata_d = wdata_data_i;
              strb_d  = wdata_strb_i;
              we_d    = 1'b1;
            end
            ARB_PORT_RDATA: begin
              addr_d  = rdata_addr_i;
              wdata_d = '0;
              strb_d  = rdata_strb_i;
              we_d    = 1'b0;
            end
            default: begin
              addr_d  = instr_addr_i;
              wdata_d = '0;
              strb_d  = ARB_FETCH_STRB[StrbWidth-1:0];
              we_d    = 1'b0;
            end
          endcase
        end
      end
      ARB_REQ:  if (mem_ready_i) state_d = ARB_RESP;
      ARB_RESP: if (mem_valid_i) state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      port_q  <= ARB_PORT_INSTR;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      we_q    <= we_d;
    end
  end

  // Payload is only presented while requesting so the bus sees zeros otherwise.
  assign mem_req_o   = in_req;
  assign mem_we_o    = in_req & we_q;
  assign mem_addr_o  = in_req ? addr_q : '0;
  assign mem_wdata_o = in_req ? wdata_q : '0;
  assign mem_strb_o  = in_req ? strb_q : '0;

  // Handshakes are gated by state so stray bus strobes never reach a port.
  assign instr_ready_o = in_req & mem_ready_i & (port_q == ARB_PORT_INSTR);
  assign rdata_ready_o = in_req & mem_ready_i & (port_q == ARB_PORT_RDATA);
  assign wdata_ready_o = in_req & mem_ready_i & (port_q == ARB_PORT_WDATA);

  assign instr_valid_o = in_resp & mem_valid_i & (port_q == ARB_PORT_INSTR);
  assign rdata_valid_o = in_resp & mem_valid_i & (port_q == ARB_PORT_RDATA);
  assign wdata_valid_o = in_resp & mem_valid_i & (port_q == ARB_PORT_WDATA);

  assign instr_rdata_o = instr_valid_o ? mem_rdata_i : '0;
  assign rdata_data_o  = rdata_valid_o ? mem_rdata_i : '0;

  assign busy_o = (state_q != ARB_IDLE);

endmodule
